// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned DataW    = 32;
  localparam int unsigned NumRegs  = 32;

  localparam logic [DataW-1:0] ZeroWord = '0;

  typedef enum logic [0:0] {
    StNormal,
    StDrain
  } state_e;

  typedef struct packed {
    logic [RegAddrW-1:0] waddr;
    logic [DataW-1:0]    wdata;
  } wb_req_t;

  // One-hot mask for a register index.
  function automatic logic [NumRegs-1:0] reg_onehot(input logic [RegAddrW-1:0] r);
    logic [NumRegs-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of multicycle writeback results {waddr, wdata}.
// Exposes per-entry liveness and target address so the top can build its pending mask.
module wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  wb_req_t                            push_data,
  input  logic                               pop,
  output wb_req_t                            head,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               full,
  output logic                               empty,
  output logic [DEPTH-1:0]                   ent_valid,
  output logic [DEPTH-1:0][RegAddrW-1:0]     ent_waddr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;
  logic [PtrW-1:0] offs;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer and count next state; push when full and pop when empty are ignored.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Entry i is live when its ring distance from the read pointer is below the count.
  always_comb begin
    offs = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offs         = PtrW'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, offs} < count_q);
      ent_waddr[i] = mem_q[i].waddr;
    end
  end

  // Storage is not reset; only live entries are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, multicycle results
// queue and are drained by a starvation guard that stalls the pipeline for one cycle.
// Optional: define REGFILE_WB_BYPASS_EN to let an M result skip the empty queue.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p_we,
  input  logic [RegAddrW-1:0] p_waddr,
  input  logic [DataW-1:0]    p_wdata,
  output logic                p_stall,
  input  logic                m_valid,
  input  logic [RegAddrW-1:0] m_waddr,
  input  logic [DataW-1:0]    m_wdata,
  output logic                m_ready,
  output logic                we,
  output logic [RegAddrW-1:0] waddr,
  output logic [DataW-1:0]    wdata,
  output logic [NumRegs-1:0]  pend,
  output logic                waw_err
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [RegAddrW-1:0]   waddr_q, waddr_d;
  logic [DataW-1:0]      wdata_q, wdata_d;
  logic                  p_stall_q, p_stall_d;
  logic                  waw_err_q, waw_err_d;

  logic                              fifo_push, fifo_pop;
  wb_req_t                           fifo_head;
  logic [$clog2(FIFO_DEPTH):0]       fifo_count;
  logic                              fifo_full, fifo_empty;
  logic [FIFO_DEPTH-1:0]             fifo_valid;
  logic [FIFO_DEPTH-1:0][RegAddrW-1:0] fifo_waddr;
  logic                              m_keep, p_req, bypass;
  logic                              unused_fifo_count;

  assign unused_fifo_count = ^fifo_count;

  wb_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({m_waddr, m_wdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (fifo_valid),
    .ent_waddr (fifo_waddr)
  );

  assign m_ready = !fifo_full;
  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign p_stall = p_stall_q;
  assign waw_err = waw_err_q;

  // Pending mask: OR of the targets of all live queue entries (r0 is never queued).
  always_comb begin
    pend = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (fifo_valid[i]) begin
        pend = pend | reg_onehot(fifo_waddr[i]);
      end
    end
  end

  // Arbitration, starvation guard and next-state for the registered write port.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    waddr_d   = '0;
    wdata_d   = ZeroWord;
    p_stall_d = 1'b0;
    waw_err_d = 1'b0;
    fifo_pop  = 1'b0;
    bypass    = 1'b0;
    // r0 writes are accepted but never queued or driven.
    m_keep    = m_valid && !fifo_full && (m_waddr != '0);
    p_req     = p_we && (p_waddr != '0);

    unique case (state_q)
      StNormal: begin
        waw_err_d = p_req && pend[p_waddr];
        if (p_req) begin
          we_d    = 1'b1;
          waddr_d = p_waddr;
          wdata_d = p_wdata;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = 1'b1;
          waddr_d  = fifo_head.waddr;
          wdata_d  = fifo_head.wdata;
`ifdef REGFILE_WB_BYPASS_EN
        end else if (m_keep && !p_we) begin
          bypass  = 1'b1;
          we_d    = 1'b1;
          waddr_d = m_waddr;
          wdata_d = m_wdata;
`endif
        end
        // Non-empty and not popped here means the pipeline took the port.
        if (fifo_empty || fifo_pop) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        if (cnt_d == 4'(STARVE_MAX)) begin
          state_d   = StDrain;
          p_stall_d = 1'b1;
        end
      end
      StDrain: begin
        // Pipeline is stalled; any p_we here is a protocol violation and is dropped.
        waw_err_d = p_we;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = 1'b1;
          waddr_d  = fifo_head.waddr;
          wdata_d  = fifo_head.wdata;
        end
        cnt_d   = '0;
        state_d = StNormal;
      end
      default: begin
        cnt_d   = '0;
        state_d = StNormal;
      end
    endcase

    fifo_push = m_keep && !bypass;
  end

  // FSM state, starvation counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StNormal;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= ZeroWord;
      p_stall_q <= 1'b0;
      waw_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      p_stall_q <= p_stall_d;
      waw_err_q <= waw_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_regfile_wb_arbiter;

  localparam int unsigned Depth     = 2;
  localparam int unsigned StarveMax = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk, rst;
  logic        p_we, m_valid;
  logic [4:0]  p_waddr, m_waddr;
  logic [31:0] p_wdata, m_wdata;
  logic        p_stall, m_ready, we, waw_err;
  logic [4:0]  waddr;
  logic [31:0] wdata, pend;

  regfile_wb_arbiter #(
    .FIFO_DEPTH(Depth),
    .STARVE_MAX(StarveMax)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .p_we    (p_we),
    .p_waddr (p_waddr),
    .p_wdata (p_wdata),
    .p_stall (p_stall),
    .m_valid (m_valid),
    .m_waddr (m_waddr),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .pend    (pend),
    .waw_err (waw_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: queued results in order, lost-cycle count, drain flag,
  // and the values the registered outputs must show after the next edge.
  ent_t        mq[$];
  int          starve;
  bit          drain;
  logic        e_we, e_stall, e_waw;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  int n_pass, n_fail, n_total;

  function automatic logic [31:0] pend_of();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    starve  = 0;
    drain   = 0;
    e_we    = 0;
    e_stall = 0;
    e_waw   = 0;
    e_waddr = 0;
    e_wdata = 0;
  endtask

  task automatic model_step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                            input logic mv, input logic [4:0] ma, input logic [31:0] md);
    bit          acc, took, byp;
    logic [31:0] pm;
    ent_t        h;
    acc  = mv && (mq.size() < int'(Depth));
    pm   = pend_of();
    took = 0;
    byp  = 0;
    e_we = 0; e_waddr = 0; e_wdata = 0; e_stall = 0; e_waw = 0;
    if (drain) begin
      e_waw = pwe;
      if (mq.size() != 0) begin
        h = mq.pop_front();
        e_we = 1; e_waddr = h.a; e_wdata = h.d;
      end
      starve = 0;
      drain  = 0;
    end else begin
      e_waw = pwe && (pa != 0) && pm[pa];
      if (pwe && pa != 0) begin
        e_we = 1; e_waddr = pa; e_wdata = pd;
      end else if (mq.size() != 0) begin
        h = mq.pop_front();
        took = 1;
        e_we = 1; e_waddr = h.a; e_wdata = h.d;
`ifdef REGFILE_WB_BYPASS_EN
      end else if (acc && ma != 0 && !pwe) begin
        byp = 1;
        e_we = 1; e_waddr = ma; e_wdata = md;
`endif
      end
      if (took || mq.size() == 0) starve = 0;
      else starve++;
      if (starve == int'(StarveMax)) begin
        drain   = 1;
        e_stall = 1;
      end
    end
    if (acc && ma != 0 && !byp) mq.push_back({ma, md});
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cycle(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    logic exp_rdy;
    p_we = pwe; p_waddr = pa; p_wdata = pd;
    m_valid = mv; m_waddr = ma; m_wdata = md;
    #1;
    exp_rdy = (mq.size() < int'(Depth));
    check("m_ready", {31'b0, m_ready}, {31'b0, exp_rdy});
    check("pend", pend, pend_of());
    model_step(pwe, pa, pd, mv, ma, md);
    @(posedge clk);
    #1;
    check("we", {31'b0, we}, {31'b0, e_we});
    if (e_we) begin
      check("waddr", {27'b0, waddr}, {27'b0, e_waddr});
      check("wdata", wdata, e_wdata);
    end
    check("p_stall", {31'b0, p_stall}, {31'b0, e_stall});
    check("waw_err", {31'b0, waw_err}, {31'b0, e_waw});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, {31'b0, we}, 32'd0);
    check({tag, "_waddr"}, {27'b0, waddr}, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_p_stall"}, {31'b0, p_stall}, 32'd0);
    check({tag, "_waw_err"}, {31'b0, waw_err}, 32'd0);
    check({tag, "_pend"}, pend, 32'd0);
    check({tag, "_m_ready"}, {31'b0, m_ready}, 32'd1);
  endtask

  ent_t src[$];
  ent_t s;
  logic rdy, mvv, r_pwe, r_mv;
  logic [4:0]  r_pa, r_ma;
  logic [31:0] r_pd, r_md;

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b0;
    p_we = 0; p_waddr = 0; p_wdata = 0;
    m_valid = 0; m_waddr = 0; m_wdata = 0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Pipeline write appears on the port one cycle later, then drops.
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    check("t1_we", {31'b0, we}, 32'd1);
    check("t1_waddr", {27'b0, waddr}, 32'd5);
    check("t1_wdata", wdata, 32'h1234);
    idle(1);
    check("t1_we_off", {31'b0, we}, 32'd0);

    // Lone multicycle result through the queue.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD);
    idle(3);

    // Continuous pipeline writes starve three queued results; drains interleave.
    src.delete();
    src.push_back({5'd8, 32'h0800});
    src.push_back({5'd9, 32'h0900});
    src.push_back({5'd10, 32'h0A00});
    for (int k = 0; k < 18; k++) begin
      mvv = (src.size() != 0);
      s   = mvv ? src[0] : '0;
      rdy = (mq.size() < int'(Depth));
      cycle(!e_stall, 5'(20 + k % 4), 32'(k), mvv, s.a, s.d);
      if (mvv && rdy) void'(src.pop_front());
    end
    idle(3);

    // r0 writes from both sides are dropped.
    cycle(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd0, 32'hCAFE);
    check("r0_we", {31'b0, we}, 32'd0);
    idle(1);
    check("r0_pend", pend, 32'd0);

    // Pipeline write to a register with a queued result.
    cycle(1'b1, 5'd4, 32'h4444, 1'b1, 5'd3, 32'h3333);
    cycle(1'b1, 5'd3, 32'h5555, 1'b0, 5'd0, 32'd0);
    check("waw_pulse", {31'b0, waw_err}, 32'd1);
    idle(3);

    // Reset mid-operation with two queued entries.
    cycle(1'b1, 5'd1, 32'h1111, 1'b1, 5'd2, 32'h2222);
    cycle(1'b1, 5'd1, 32'h1112, 1'b1, 5'd6, 32'h6666);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4);

    // Random traffic over a small register range to provoke conflicts.
    for (int k = 0; k < 400; k++) begin
      r_pwe = ($urandom_range(9, 0) < 7) && (!e_stall || $urandom_range(7, 0) == 0);
      r_pa  = 5'($urandom_range(7, 0));
      r_pd  = $urandom;
      r_mv  = ($urandom_range(2, 0) == 0);
      r_ma  = 5'($urandom_range(7, 0));
      r_md  = $urandom;
      cycle(r_pwe, r_pa, r_pd, r_mv, r_ma, r_md);
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
